// File: rtl/md_arbiter.sv
// md_arbiter: two-requester front end for a shared multiply/divide unit.
//
// One operation is in flight at a time. An IDLE cycle picks a winner, accepts
// it combinationally (reqN_ready), latches op/operands/owner, then either
// starts the unit (legal op) or answers straight away with rsp_err (illegal op).
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   reqN_valid/op/a/b   requester N operation (N = 0, 1); op 0..3 legal
//   reqN_ready          accept strobe, only in IDLE and only for the winner
//   rspN_valid          one-cycle completion pulse to requester N
//   rsp_hi/lo, rsp_err  shared result bus, meaningful with a rspN_valid
//   md_start/op/a/b     command to the shared unit (start is a 1-cycle pulse)
//   md_busy/hi/lo       unit status and result
//   owner               requester currently being served
//
// Configuration: define MD_ARB_ROUND_ROBIN_EN for round-robin arbitration on
// conflict; otherwise requester 0 has fixed priority.
module md_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        rsp_err,
    output logic        md_start,
    output logic [2:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        owner
);

    typedef enum logic [1:0] {StIdle, StIssue, StRun, StResp} state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        owner_q, owner_d;
`ifdef MD_ARB_ROUND_ROBIN_EN
    logic        last_grant_q, last_grant_d;
`endif

    logic        any_req;
    logic        win;
    logic [2:0]  win_op;
    logic [31:0] win_a;
    logic [31:0] win_b;

    // Winner selection; win is only meaningful while any_req is set.
    always_comb begin
        any_req = req0_valid | req1_valid;
`ifdef MD_ARB_ROUND_ROBIN_EN
        if (req0_valid && req1_valid) begin
            win = ~last_grant_q;
        end else begin
            win = ~req0_valid;
        end
`else
        win = ~req0_valid;
`endif
        win_op = win ? req1_op : req0_op;
        win_a  = win ? req1_a  : req0_a;
        win_b  = win ? req1_b  : req0_b;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        owner_d    = owner_q;
`ifdef MD_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp_hi     = '0;
        rsp_lo     = '0;
        rsp_err    = 1'b0;
        md_start   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    req0_ready = ~win;
                    req1_ready = win;
                    op_d       = win_op;
                    a_d        = win_a;
                    b_d        = win_b;
                    owner_d    = win;
`ifdef MD_ARB_ROUND_ROBIN_EN
                    last_grant_d = win;
`endif
                    // Ops 4..7 never reach the unit.
                    state_d    = win_op[2] ? StResp : StIssue;
                end
            end
            StIssue: begin
                md_start = 1'b1;
                state_d  = StRun;
            end
            StRun: begin
                // Unit raises busy the cycle after start, so the first RUN
                // cycle never sees a stale busy=0.
                if (!md_busy) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                rsp0_valid = ~owner_q;
                rsp1_valid = owner_q;
                if (op_q[2]) begin
                    rsp_err = 1'b1;
                end else begin
                    rsp_hi = md_hi;
                    rsp_lo = md_lo;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            owner_q <= 1'b0;
`ifdef MD_ARB_ROUND_ROBIN_EN
            // Requester 0 wins the first conflict after reset.
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            owner_q <= owner_d;
`ifdef MD_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign md_op = op_q;
    assign md_a  = a_q;
    assign md_b  = b_q;
    assign owner = owner_q;

endmodule

// File: doc/md_arbiter.md
MD_ARBITER -- requirements
Module: md_arbiter

Interface
- REQ-001 SHALL: clk  in  1  clock; all state updates on posedge.
- REQ-002 SHALL: reset  in  1  reset, synchronous, active-high.
- REQ-003 SHALL: reqN_valid  in  1  requester N (N=0,1) has an operation pending.
- REQ-004 SHALL: reqN_op  in  3  0=mult, 1=multu, 2=div, 3=divu, 4..7 illegal.
- REQ-005 SHALL: reqN_a, reqN_b  in  32 each  operands.
- REQ-006 SHALL: reqN_ready  out  1  accept strobe; transfer when reqN_valid && reqN_ready.
- REQ-007 SHALL: rspN_valid  out  1  one-cycle completion pulse to requester N.
- REQ-008 SHALL: rsp_hi, rsp_lo  out  32 each  result; meaningful only while a rspN_valid is 1.
- REQ-009 SHALL: rsp_err  out  1  set with rspN_valid when the accepted op was illegal.
- REQ-010 SHALL: md_start  out  1; md_op  out  3; md_a, md_b  out  32  drive to the shared mult/div unit.
- REQ-011 SHALL: md_busy  in  1; md_hi, md_lo  in  32  status and results from the unit.
- REQ-012 SHALL: owner  out  1  index of requester currently served (valid when not IDLE).

Function
- REQ-013 SHALL: FSM states IDLE, ISSUE, RUN, RESP; one operation in flight at a time.
- REQ-014 SHALL: IDLE: if any reqN_valid, select winner, assert its reqN_ready combinationally that cycle, latch op/a/b/owner, go ISSUE (legal op) or RESP (illegal op).
- REQ-015 SHALL: reqN_ready is 0 in every state except IDLE and 0 for the non-winner.
- REQ-016 SHALL: ISSUE: md_start=1 for exactly one cycle with latched md_op/md_a/md_b; next state RUN.
- REQ-017 SHALL: md_op/md_a/md_b hold latched values from ISSUE through RUN; md_start=0 outside ISSUE.
- REQ-018 SHALL: RUN: stay while md_busy=1; on md_busy=0 go RESP (unit raises busy the cycle after start; first RUN cycle sees busy=1).
- REQ-019 SHALL: RESP: assert rsp{owner}_valid=1 for one cycle, rsp_hi=md_hi, rsp_lo=md_lo, rsp_err=0; next IDLE.
- REQ-020 SHALL: illegal op in RESP: rsp_hi=rsp_lo=0, rsp_err=1, unit never started.
- REQ-021 SHALL: latency legal op = 3 + unit busy cycles from accept to rspN_valid; illegal op = 1 cycle.
- REQ-022 SHALL: a request arriving during ISSUE/RUN/RESP waits; earliest acceptance is the IDLE cycle after RESP.
- REQ-023 SHALL: requester deasserting valid before ready is not served and causes no response.
- REQ-024 SHALL: at most one rspN_valid high per cycle; rsp_err=0 whenever no rspN_valid.

Reset
- REQ-025 SHALL: on reset: state IDLE, all outputs 0, owner=0, latched operands 0, last_grant=1.
- REQ-026 SHALL: reset mid-operation aborts it; no response pulse is ever emitted for it.

Configuration
- REQ-027 SHALL: macro MD_ARB_ROUND_ROBIN_EN defined: both valid in IDLE -> grant requester != last_grant; last_grant updated on every grant.
- REQ-028 SHALL: macro undefined: fixed priority, requester 0 always wins on conflict; last_grant unused.
- REQ-029 SHALL: single-requester behaviour identical in both configurations.

Verification
- REQ-030 SHALL: req0 mult a=0xFFFFFFFF b=2 (unit busy 5) -> md_start 1 cycle after accept, rsp0_valid 8 cycles after accept, hi=0xFFFFFFFF lo=0xFFFFFFFE.
- REQ-031 SHALL: req1 divu a=100 b=7 (busy 10) -> rsp1_valid 13 cycles after accept, hi=2 lo=14, rsp0_valid stays 0.
- REQ-032 SHALL: both valid continuously, 4 ops each -> with MD_ARB_ROUND_ROBIN_EN grants 0,1,0,1...; without it all req0 ops complete before any req1 accept.
- REQ-033 SHALL: req0 op=5 -> accepted, next cycle rsp0_valid=1 rsp_err=1 hi=lo=0, md_start never asserted.
- REQ-034 SHALL: reset asserted 2 cycles into RUN -> next cycle state IDLE, no rspN_valid, new request accepted immediately after reset release.
- REQ-035 SHALL: req1 valid during req0 RUN -> req1_ready 0 until the IDLE cycle following rsp0_valid, then 1.
